// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: widths, rotation amounts, quarterround index tables, FSM encoding.
package chacha_pkg;

    localparam int unsigned CHACHA_STATE_W = 512;
    localparam int unsigned CHACHA_WORD_W  = 32;
    localparam int unsigned CHACHA_WORDS   = CHACHA_STATE_W / CHACHA_WORD_W;
    localparam int unsigned NUM_LANES      = 4;
    localparam int unsigned ROUNDS_W       = 5;
    localparam int unsigned DR_W           = 4;
    localparam int unsigned WIDX_W         = 4;
    localparam int unsigned DEF_ROUNDS     = 20;

    localparam int unsigned ROT_16 = 16;
    localparam int unsigned ROT_12 = 12;
    localparam int unsigned ROT_8  = 8;
    localparam int unsigned ROT_7  = 7;

    typedef logic [CHACHA_WORD_W-1:0] word_t;
    typedef logic [WIDX_W-1:0]        widx_t;

    // Word 0 is the most significant word, matching the external state ordering.
    typedef logic [0:CHACHA_WORDS-1][CHACHA_WORD_W-1:0] state_t;

    // Quarterround word indices as [lane][a,b,c,d].
    localparam logic [0:NUM_LANES-1][0:3][WIDX_W-1:0] COL_IDX = {
        4'd0, 4'd4, 4'd8,  4'd12,
        4'd1, 4'd5, 4'd9,  4'd13,
        4'd2, 4'd6, 4'd10, 4'd14,
        4'd3, 4'd7, 4'd11, 4'd15
    };

    localparam logic [0:NUM_LANES-1][0:3][WIDX_W-1:0] DIAG_IDX = {
        4'd0, 4'd5, 4'd10, 4'd15,
        4'd1, 4'd6, 4'd11, 4'd12,
        4'd2, 4'd7, 4'd8,  4'd13,
        4'd3, 4'd4, 4'd9,  4'd14
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIAG = 2'd1,
        ST_COL  = 2'd2
    } fsm_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (CHACHA_WORD_W - n));
    endfunction

    function automatic widx_t qr_idx(input logic diag, input logic [1:0] lane, input logic [1:0] pos);
        return diag ? DIAG_IDX[lane][pos] : COL_IDX[lane][pos];
    endfunction

endpackage

// File: rtl/chacha_inv_rounds_if.sv
// Request/response bundle between a client and the inverse-round engine.
interface chacha_inv_rounds_if;
    import chacha_pkg::*;

    logic                      start;
    logic [ROUNDS_W-1:0]       rounds_in;
    logic [CHACHA_STATE_W-1:0] state_in;
    logic                      ready;
    logic [CHACHA_STATE_W-1:0] state_out;
    logic                      out_valid;

    modport master (
        output start, rounds_in, state_in,
        input  ready, state_out, out_valid
    );

    modport slave (
        input  start, rounds_in, state_in,
        output ready, state_out, out_valid
    );

endinterface

// File: rtl/chacha_qr_inv.sv
// Combinational inverse ChaCha quarterround; all arithmetic wraps mod 2^32.
module chacha_qr_inv
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_prim,
    output word_t b_prim,
    output word_t c_prim,
    output word_t d_prim
);

    word_t a1, b1, c1, d1, b2, c2, d2;

    // Forward steps undone in reverse order: the 8/7 half first, then the 16/12 half.
    assign b1 = rotr(b, ROT_7) ^ c;
    assign c1 = c - d;
    assign d1 = rotr(d, ROT_8) ^ a;
    assign a1 = a - b1;

    assign b2 = rotr(b1, ROT_12) ^ c1;
    assign c2 = c1 - d1;
    assign d2 = rotr(d1, ROT_16) ^ a1;

    assign a_prim = a1 - b2;
    assign b_prim = b2;
    assign c_prim = c2;
    assign d_prim = d2;

endmodule

// File: rtl/chacha_inv_rounds.sv
// Iterative inverse ChaCha round engine: one inverse half-round (4 lanes) per clock, diagonal first.
module chacha_inv_rounds
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    chacha_inv_rounds_if.slave bus
);

    fsm_t                state_q, state_d;
    logic [DR_W-1:0]     dr_ctr_q, dr_ctr_d;
    logic [DR_W-1:0]     dr_q, dr_d;
    state_t              work_q, work_d;
    state_t              res_c;
    logic [CHACHA_STATE_W-1:0] state_out_q, state_out_d;
    logic                out_valid_q, out_valid_d;
    logic                ready_q, ready_d;

    logic                          diag_c;
    logic [0:NUM_LANES-1][0:3][CHACHA_WORD_W-1:0] lane_in_c;
    word_t                         lane_out_c [NUM_LANES][4];
    logic                          unused_rounds_lsb_c;

    assign diag_c              = (state_q == ST_DIAG);
    assign unused_rounds_lsb_c = bus.rounds_in[0];

    // Gather each lane's (a,b,c,d) from the working register for the current half-round.
    always_comb begin
        lane_in_c = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int p = 0; p < 4; p++) begin
                lane_in_c[2'(l)][2'(p)] = work_q[qr_idx(diag_c, 2'(l), 2'(p))];
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        chacha_qr_inv u_qr_inv (
            .a      (lane_in_c[l][0]),
            .b      (lane_in_c[l][1]),
            .c      (lane_in_c[l][2]),
            .d      (lane_in_c[l][3]),
            .a_prim (lane_out_c[l][0]),
            .b_prim (lane_out_c[l][1]),
            .c_prim (lane_out_c[l][2]),
            .d_prim (lane_out_c[l][3])
        );
    end

    // Scatter lane results back to their word positions; each word belongs to exactly one lane.
    always_comb begin
        res_c = work_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int p = 0; p < 4; p++) begin
                res_c[qr_idx(diag_c, 2'(l), 2'(p))] = lane_out_c[2'(l)][2'(p)];
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        dr_ctr_d    = dr_ctr_q;
        dr_d        = dr_q;
        work_d      = work_q;
        state_out_d = state_out_q;
        out_valid_d = out_valid_q;
        ready_d     = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && ready_q) begin
                    work_d      = state_t'(bus.state_in);
                    dr_d        = bus.rounds_in[ROUNDS_W-1:1];
                    dr_ctr_d    = '0;
                    out_valid_d = 1'b0;
                    ready_d     = 1'b0;
                    if (bus.rounds_in[ROUNDS_W-1:1] != '0) begin
                        state_d = ST_DIAG;
                    end
                end else if (!ready_q) begin
                    // Zero-round request: pass the latched state straight through.
                    state_out_d = CHACHA_STATE_W'(work_q);
                    out_valid_d = 1'b1;
                    ready_d     = 1'b1;
                end
            end
            ST_DIAG: begin
                work_d  = res_c;
                state_d = ST_COL;
            end
            ST_COL: begin
                work_d   = res_c;
                dr_ctr_d = dr_ctr_q + DR_W'(1);
                if (dr_ctr_q == dr_q - DR_W'(1)) begin
                    state_d     = ST_IDLE;
                    state_out_d = CHACHA_STATE_W'(res_c);
                    out_valid_d = 1'b1;
                    ready_d     = 1'b1;
                end else begin
                    state_d = ST_DIAG;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dr_ctr_q    <= '0;
            dr_q        <= '0;
            work_q      <= '0;
            state_out_q <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            dr_ctr_q    <= dr_ctr_d;
            dr_q        <= dr_d;
            work_q      <= work_d;
            state_out_q <= state_out_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.state_out = state_out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_chacha_inv_rounds.sv
// Bench for chacha_inv_rounds: forward-round reference model, RFC 8439 vectors, protocol corner cases.
module tb_chacha_inv_rounds;
    import chacha_pkg::*;

    typedef logic [31:0] w32;
    typedef w32 words_t [16];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chacha_inv_rounds_if bus();

    chacha_inv_rounds dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    w32 qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

    chacha_qr_inv u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_prim(qa_o), .b_prim(qb_o), .c_prim(qc_o), .d_prim(qd_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] exp_state = '0;
    logic         exp_armed = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Forward ChaCha reference, written straight from the round definition.
    function automatic w32 rotl(input w32 x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic words_t qr_fwd(input words_t s, input int ia, input int ib, input int ic, input int id);
        s[ia] += s[ib]; s[id] ^= s[ia]; s[id] = rotl(s[id], 16);
        s[ic] += s[id]; s[ib] ^= s[ic]; s[ib] = rotl(s[ib], 12);
        s[ia] += s[ib]; s[id] ^= s[ia]; s[id] = rotl(s[id], 8);
        s[ic] += s[id]; s[ib] ^= s[ic]; s[ib] = rotl(s[ib], 7);
        return s;
    endfunction

    function automatic words_t fwd_rounds(input words_t s, input int dr);
        for (int r = 0; r < dr; r++) begin
            s = qr_fwd(s, 0, 4, 8, 12);  s = qr_fwd(s, 1, 5, 9, 13);
            s = qr_fwd(s, 2, 6, 10, 14); s = qr_fwd(s, 3, 7, 11, 15);
            s = qr_fwd(s, 0, 5, 10, 15); s = qr_fwd(s, 1, 6, 11, 12);
            s = qr_fwd(s, 2, 7, 8, 13);  s = qr_fwd(s, 3, 4, 9, 14);
        end
        return s;
    endfunction

    function automatic logic [511:0] pack(input words_t s);
        logic [511:0] p = '0;
        for (int i = 0; i < 16; i++) p = {p[479:0], s[i]};
        return p;
    endfunction

    function automatic words_t rand_words();
        words_t s;
        for (int i = 0; i < 16; i++) s[i] = $urandom;
        return s;
    endfunction

    // Every cycle a result is presented it must equal the pre-round state of the outstanding request.
    always @(posedge clk) begin
        #1;
        if (!reset && exp_armed && bus.out_valid)
            chk("monitor_state_out", bus.state_out, exp_state);
    end

    task automatic wait_valid(output int cnt);
        cnt = 1;
        while (!bus.out_valid && cnt < 100) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            cnt++;
        end
    endtask

    task automatic run_req(input string name, input logic [4:0] rnd, input words_t pre,
                           input int exp_lat, input int pulse_at);
        words_t post;
        int cnt;
        post = fwd_rounds(pre, int'(rnd[4:1]));
        @(negedge clk);
        chk({name, "_ready_before"}, 512'(bus.ready), 512'(1));
        bus.start     = 1'b1;
        bus.rounds_in = rnd;
        bus.state_in  = pack(post);
        exp_state     = pack(pre);
        exp_armed     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.state_in  = pack(rand_words());
        bus.rounds_in = 5'd31;
        chk({name, "_valid_at_accept"}, 512'(bus.out_valid), 512'(0));
        chk({name, "_ready_at_accept"}, 512'(bus.ready), 512'(0));
        cnt = 1;
        while (!bus.out_valid && cnt < 100) begin
            if (cnt == pulse_at) begin
                bus.start     = 1'b1;
                bus.rounds_in = 5'd2;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cnt++;
        end
        chk({name, "_latency"}, 512'(cnt), 512'(exp_lat));
        chk({name, "_state_out"}, bus.state_out, pack(pre));
        chk({name, "_ready_after"}, 512'(bus.ready), 512'(1));
    endtask

    words_t init_st, ks, post_rfc, wa, wb;
    logic [127:0] q4;
    int cnt;

    initial begin
        init_st = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        ks      = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        for (int i = 0; i < 16; i++) post_rfc[i] = ks[i] - init_st[i];

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.rounds_in = '0;
        bus.state_in  = '0;
        qa = 32'hea2a92f4; qb = 32'hcb1cf8ce; qc = 32'h4581472e; qd = 32'h5881c4bb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",     512'(bus.ready),     512'(1));
        chk("reset_out_valid", 512'(bus.out_valid), 512'(0));
        chk("reset_state_out", bus.state_out,       512'(0));

        // Standalone inverse quarterround against the RFC 8439 2.1.1 vector.
        chk("qr_inv_a", 512'(qa_o), 512'(32'h11111111));
        chk("qr_inv_b", 512'(qb_o), 512'(32'h01020304));
        chk("qr_inv_c", 512'(qc_o), 512'(32'h9b8d6f43));
        chk("qr_inv_d", 512'(qd_o), 512'(32'h01234567));

        // Pin the reference model to the same literals.
        wa = '{default: 32'h0};
        wa[0] = 32'h11111111; wa[1] = 32'h01020304; wa[2] = 32'h9b8d6f43; wa[3] = 32'h01234567;
        wa = qr_fwd(wa, 0, 1, 2, 3);
        q4 = {wa[0], wa[1], wa[2], wa[3]};
        chk("model_qr_fwd", 512'(q4), 512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));
        chk("model_rfc_block", pack(fwd_rounds(init_st, 10)), pack(post_rfc));

        reset = 1'b0;
        @(negedge clk);

        // RFC 8439 2.3.2 block with a literal expectation.
        run_req("rfc_block", 5'd20, init_st, 21, -1);
        chk("rfc_block_literal", bus.state_out, pack(init_st));

        run_req("rt8",  5'd8,  rand_words(), 9,  -1);
        run_req("rt12", 5'd12, rand_words(), 13, 5);
        run_req("rt20", 5'd20, rand_words(), 21, -1);
        run_req("r0",   5'd0,  rand_words(), 2,  1);
        run_req("r1",   5'd1,  rand_words(), 2,  -1);
        run_req("r21",  5'd21, rand_words(), 21, 10);

        // Back-to-back with start held high throughout.
        wa = rand_words();
        wb = rand_words();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.rounds_in = 5'd8;
        bus.state_in  = pack(fwd_rounds(wa, 4));
        exp_state     = pack(wa);
        exp_armed     = 1'b1;
        @(posedge clk); #1;
        cnt = 1;
        while (!bus.out_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("b2b_a_latency",   512'(cnt), 512'(9));
        chk("b2b_a_state_out", bus.state_out, pack(wa));
        chk("b2b_a_ready",     512'(bus.ready), 512'(1));
        @(negedge clk);
        bus.rounds_in = 5'd12;
        bus.state_in  = pack(fwd_rounds(wb, 6));
        exp_state     = pack(wb);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_b_valid_drop", 512'(bus.out_valid), 512'(0));
        chk("b2b_b_ready_drop", 512'(bus.ready),     512'(0));
        wait_valid(cnt);
        chk("b2b_b_latency",   512'(cnt), 512'(13));
        chk("b2b_b_state_out", bus.state_out, pack(wb));

        // Reset after five half-rounds of a 20-round run.
        wa = rand_words();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.rounds_in = 5'd20;
        bus.state_in  = pack(fwd_rounds(wa, 10));
        exp_armed     = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_ready",     512'(bus.ready),     512'(1));
        chk("midreset_out_valid", 512'(bus.out_valid), 512'(0));
        chk("midreset_state_out", bus.state_out,       512'(0));
        reset = 1'b0;
        run_req("after_reset", 5'd20, rand_words(), 21, -1);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
